dsi_timing_ctrl: RTL and testbench

DSI_TIMING_CTRL -- requirements
Module: dsi_timing_ctrl

---
 rtl/dsi_timing_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dsi_timing_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_timing_ctrl.sv
// DSI video timing generator: frame/line counters with registered sync, data-enable and event outputs.
// Optional macro DSI_TMG_SYNC_END_EN adds the VSYNC_minus/HSYNC_minus sync-end pulses.
module dsi_timing_ctrl (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] hsa,
  input  logic [11:0] hbp,
  input  logic [11:0] hact,
  input  logic [11:0] hfp,
  input  logic [10:0] vsa,
  input  logic [10:0] vbp,
  input  logic [10:0] vact,
  input  logic [10:0] vfp,
  input  logic        pix_valid,
  input  logic        udf_clr,
  output logic        VSYNC,
  output logic        HSYNC,
  output logic        DATA_ENB,
  output logic        VSYNC_plus,
  output logic        HSYNC_plus,
  output logic        VSYNC_minus,
  output logic        HSYNC_minus,
  output logic        busy,
  output logic        underflow,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_hsa, r_hbp, r_hact, r_hfp;
  logic [10:0] r_vsa, r_vbp, r_vact, r_vfp;
  logic [11:0] w_hsa_n, w_hbp_n, w_hact_n, w_hfp_n;
  logic [10:0] w_vsa_n, w_vbp_n, w_vact_n, w_vfp_n;
  logic [13:0] r_h, w_h_n, w_htot, w_hde_beg, w_hde_end;
  logic [12:0] r_v, w_v_n, w_vtot, w_vde_beg, w_vde_end;
  logic        w_last, w_lat, w_run_n;
  logic        r_vsync, r_hsync, r_de, r_vsync_p, r_hsync_p, r_udf;
  logic [15:0] r_frame_cnt;

  assign w_htot = {2'b00, r_hsa} + {2'b00, r_hbp} + {2'b00, r_hact} + {2'b00, r_hfp};
  assign w_vtot = {2'b00, r_vsa} + {2'b00, r_vbp} + {2'b00, r_vact} + {2'b00, r_vfp};
  assign w_last = (r_state != ST_IDLE) && (r_h == w_htot - 14'd1) && (r_v == w_vtot - 13'd1);
  assign w_lat  = ((r_state == ST_IDLE) && en) || w_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (en) w_state_nxt = ST_RUN;
      ST_RUN:       if (!en) w_state_nxt = ST_STOP_PEND;
      ST_STOP_PEND: begin
        if (w_last)  w_state_nxt = ST_IDLE;
        else if (en) w_state_nxt = ST_RUN;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Sync and active lengths of 0 count as 1; porches of 0 simply vanish.
  always_comb begin
    w_hsa_n  = r_hsa;
    w_hbp_n  = r_hbp;
    w_hact_n = r_hact;
    w_hfp_n  = r_hfp;
    w_vsa_n  = r_vsa;
    w_vbp_n  = r_vbp;
    w_vact_n = r_vact;
    w_vfp_n  = r_vfp;
    if (w_lat) begin
      w_hsa_n  = (hsa  == 12'd0) ? 12'd1 : hsa;
      w_hbp_n  = hbp;
      w_hact_n = (hact == 12'd0) ? 12'd1 : hact;
      w_hfp_n  = hfp;
      w_vsa_n  = (vsa  == 11'd0) ? 11'd1 : vsa;
      w_vbp_n  = vbp;
      w_vact_n = (vact == 11'd0) ? 11'd1 : vact;
      w_vfp_n  = vfp;
    end
  end

  assign w_run_n = (w_state_nxt != ST_IDLE);

  always_comb begin
    w_h_n = 14'd0;
    w_v_n = 13'd0;
    if (w_run_n && (r_state != ST_IDLE)) begin
      if (r_h == w_htot - 14'd1) begin
        w_h_n = 14'd0;
        w_v_n = (r_v == w_vtot - 13'd1) ? 13'd0 : r_v + 13'd1;
      end else begin
        w_h_n = r_h + 14'd1;
        w_v_n = r_v;
      end
    end
  end

  // Outputs decode the next counter values so they line up with the counters.
  assign w_hde_beg = {2'b00, w_hsa_n} + {2'b00, w_hbp_n};
  assign w_hde_end = w_hde_beg + {2'b00, w_hact_n};
  assign w_vde_beg = {2'b00, w_vsa_n} + {2'b00, w_vbp_n};
  assign w_vde_end = w_vde_beg + {2'b00, w_vact_n};

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_hsa       <= 12'd0;
      r_hbp       <= 12'd0;
      r_hact      <= 12'd0;
      r_hfp       <= 12'd0;
      r_vsa       <= 11'd0;
      r_vbp       <= 11'd0;
      r_vact      <= 11'd0;
      r_vfp       <= 11'd0;
      r_h         <= 14'd0;
      r_v         <= 13'd0;
      r_vsync     <= 1'b0;
      r_hsync     <= 1'b0;
      r_de        <= 1'b0;
      r_vsync_p   <= 1'b0;
      r_hsync_p   <= 1'b0;
      r_udf       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_hsa     <= w_hsa_n;
      r_hbp     <= w_hbp_n;
      r_hact    <= w_hact_n;
      r_hfp     <= w_hfp_n;
      r_vsa     <= w_vsa_n;
      r_vbp     <= w_vbp_n;
      r_vact    <= w_vact_n;
      r_vfp     <= w_vfp_n;
      r_h       <= w_h_n;
      r_v       <= w_v_n;
      r_hsync   <= w_run_n && (w_h_n < {2'b00, w_hsa_n});
      r_vsync   <= w_run_n && (w_v_n < {2'b00, w_vsa_n});
      r_de      <= w_run_n && (w_h_n >= w_hde_beg) && (w_h_n < w_hde_end) &&
                   (w_v_n >= w_vde_beg) && (w_v_n < w_vde_end);
      r_vsync_p <= w_run_n && (w_h_n == 14'd0) && (w_v_n == 13'd0);
      r_hsync_p <= w_run_n && (w_h_n == 14'd0) && (w_v_n != 13'd0);
      r_udf     <= (r_de && !pix_valid) || (r_udf && !udf_clr);
      if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef DSI_TMG_SYNC_END_EN
  logic r_vsync_m, r_hsync_m;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      r_vsync_m <= 1'b0;
      r_hsync_m <= 1'b0;
    end else begin
      r_vsync_m <= w_run_n && (w_h_n == 14'd0) && (w_v_n == {2'b00, w_vsa_n});
      r_hsync_m <= w_run_n && (w_h_n == {2'b00, w_hsa_n}) && (w_v_n != {2'b00, w_vsa_n});
    end
  end

  assign VSYNC_minus = r_vsync_m;
  assign HSYNC_minus = r_hsync_m;
`else
  assign VSYNC_minus = 1'b0;
  assign HSYNC_minus = 1'b0;
`endif

  assign VSYNC     = r_vsync;
  assign HSYNC     = r_hsync;
  assign DATA_ENB  = r_de;
  assign VSYNC_plus = r_vsync_p;
  assign HSYNC_plus = r_hsync_p;
  assign busy      = (r_state != ST_IDLE);
  assign underflow = r_udf;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dsi_timing_ctrl.sv
// Self-checking bench for dsi_timing_ctrl; expected waveforms come from a closed-form frame model.
// Honours DSI_TMG_SYNC_END_EN when deciding what the sync-end pulses should do.
module tb_dsi_timing_ctrl;

  typedef struct {
    int hsa, hbp, hact, hfp, vsa, vbp, vact, vfp;
  } cfg_t;

  logic        pixel_clk, rst, en, pix_valid, udf_clr;
  logic [11:0] hsa, hbp, hact, hfp;
  logic [10:0] vsa, vbp, vact, vfp;
  logic        VSYNC, HSYNC, DATA_ENB, VSYNC_plus, HSYNC_plus, VSYNC_minus, HSYNC_minus;
  logic        busy, underflow;
  logic [15:0] frame_cnt;
  logic [7:0]  w_obs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] q_exp[$];
  logic       q_udf[$];

  cfg_t cfg_a = '{2, 3, 8, 1, 1, 2, 4, 1};
  cfg_t cfg_b = '{1, 0, 4, 0, 1, 0, 2, 0};
  cfg_t cfg_c = '{0, 0, 2, 0, 1, 0, 2, 0};

  dsi_timing_ctrl dut (
    .pixel_clk(pixel_clk), .rst(rst), .en(en),
    .hsa(hsa), .hbp(hbp), .hact(hact), .hfp(hfp),
    .vsa(vsa), .vbp(vbp), .vact(vact), .vfp(vfp),
    .pix_valid(pix_valid), .udf_clr(udf_clr),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .DATA_ENB(DATA_ENB),
    .VSYNC_plus(VSYNC_plus), .HSYNC_plus(HSYNC_plus),
    .VSYNC_minus(VSYNC_minus), .HSYNC_minus(HSYNC_minus),
    .busy(busy), .underflow(underflow), .frame_cnt(frame_cnt)
  );

  assign w_obs = {busy, VSYNC, HSYNC, DATA_ENB, VSYNC_plus, HSYNC_plus, VSYNC_minus, HSYNC_minus};

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  // Bit order: busy, VSYNC, HSYNC, DATA_ENB, VSYNC_plus, HSYNC_plus, VSYNC_minus, HSYNC_minus
  function automatic logic [7:0] exp_vec(cfg_t c, int k);
    int hs, ha, vs, va, htot, vtot, h, v;
    logic [7:0] e;
    hs   = (c.hsa  == 0) ? 1 : c.hsa;
    ha   = (c.hact == 0) ? 1 : c.hact;
    vs   = (c.vsa  == 0) ? 1 : c.vsa;
    va   = (c.vact == 0) ? 1 : c.vact;
    htot = hs + c.hbp + ha + c.hfp;
    vtot = vs + c.vbp + va + c.vfp;
    h    = k % htot;
    v    = (k / htot) % vtot;
    e[7] = 1'b1;
    e[6] = (v < vs);
    e[5] = (h < hs);
    e[4] = (h >= hs + c.hbp) && (h < hs + c.hbp + ha) && (v >= vs + c.vbp) && (v < vs + c.vbp + va);
    e[3] = (h == 0) && (v == 0);
    e[2] = (h == 0) && (v != 0);
`ifdef DSI_TMG_SYNC_END_EN
    e[1] = (h == 0) && (v == vs);
    e[0] = (h == hs) && (v != vs);
`else
    e[1] = 1'b0;
    e[0] = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic apply_cfg(cfg_t c);
    hsa = 12'(c.hsa); hbp = 12'(c.hbp); hact = 12'(c.hact); hfp = 12'(c.hfp);
    vsa = 11'(c.vsa); vbp = 11'(c.vbp); vact = 11'(c.vact); vfp = 11'(c.vfp);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; pix_valid = 1'b1; udf_clr = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b0; en = 1'b1; pix_valid = 1'b0; udf_clr = 1'b0;
    apply_cfg(cfg_a);
    repeat (3) tick();
    n_checks++;
    if (w_obs !== 8'h00) $display("FAIL reset_outputs obs=%b exp=%b", w_obs, 8'h00); else n_pass++;
    n_checks++;
    if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt obs=%0d exp=0", frame_cnt); else n_pass++;
    n_checks++;
    if (underflow !== 1'b0) $display("FAIL reset_underflow obs=%b exp=0", underflow); else n_pass++;
    en = 1'b0; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q_exp.push_back(8'h00);
      tick();
      e = q_exp.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL idle_after_reset i=%0d obs=%b exp=%b", i, w_obs, e); else n_pass++;
    end
  endtask

  task automatic test_frame_timing();
    int n_de, n_vsp, n_hsp, n_vsm, n_hsm, x_vsm, x_hsm;
    logic [7:0] e;
    n_de = 0; n_vsp = 0; n_hsp = 0; n_vsm = 0; n_hsm = 0;
    do_reset();
    apply_cfg(cfg_a);
    en = 1'b1;
    for (int k = 0; k < 112; k++) begin
      q_exp.push_back(exp_vec(cfg_a, k));
      tick();
      e = q_exp.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL frame k=%0d obs=%b exp=%b", k, w_obs, e); else n_pass++;
      n_de += int'(DATA_ENB); n_vsp += int'(VSYNC_plus); n_hsp += int'(HSYNC_plus);
      n_vsm += int'(VSYNC_minus); n_hsm += int'(HSYNC_minus);
      n_checks++;
      if (VSYNC_plus && HSYNC_plus) $display("FAIL plus_overlap k=%0d obs=11 exp=not both", k); else n_pass++;
    end
`ifdef DSI_TMG_SYNC_END_EN
    x_vsm = 1; x_hsm = 7;
`else
    x_vsm = 0; x_hsm = 0;
`endif
    n_checks++;
    if (n_de !== 32) $display("FAIL de_count obs=%0d exp=32", n_de); else n_pass++;
    n_checks++;
    if (n_vsp !== 1) $display("FAIL vsync_plus_count obs=%0d exp=1", n_vsp); else n_pass++;
    n_checks++;
    if (n_hsp !== 7) $display("FAIL hsync_plus_count obs=%0d exp=7", n_hsp); else n_pass++;
    n_checks++;
    if (n_vsm !== x_vsm) $display("FAIL vsync_minus_count obs=%0d exp=%0d", n_vsm, x_vsm); else n_pass++;
    n_checks++;
    if (n_hsm !== x_hsm) $display("FAIL hsync_minus_count obs=%0d exp=%0d", n_hsm, x_hsm); else n_pass++;
    tick();
    n_checks++;
    if (frame_cnt !== 16'd1) $display("FAIL frame_cnt_after_frame obs=%0d exp=1", frame_cnt); else n_pass++;
    n_checks++;
    if (VSYNC_plus !== 1'b1) $display("FAIL second_frame_start obs=%b exp=1", VSYNC_plus); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_stop_boundary();
    logic [7:0] e;
    do_reset();
    apply_cfg(cfg_a);
    en = 1'b1;
    for (int k = 0; k < 116; k++) begin
      if (k == 40) en = 1'b0;
      q_exp.push_back((k < 112) ? exp_vec(cfg_a, k) : 8'h00);
      tick();
      e = q_exp.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL stop k=%0d obs=%b exp=%b", k, w_obs, e); else n_pass++;
    end
    n_checks++;
    if (frame_cnt !== 16'd1) $display("FAIL stop_frame_cnt obs=%0d exp=1", frame_cnt); else n_pass++;
  endtask

  task automatic test_zero_porch();
    int n_de;
    logic [7:0] e;
    n_de = 0;
    do_reset();
    apply_cfg(cfg_b);
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) apply_cfg(cfg_c);
      q_exp.push_back(exp_vec(cfg_b, k));
      tick();
      e = q_exp.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL zero_porch k=%0d obs=%b exp=%b", k, w_obs, e); else n_pass++;
      n_de += int'(DATA_ENB);
    end
    n_checks++;
    if (n_de !== 8) $display("FAIL zero_porch_de_count obs=%0d exp=8", n_de); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      q_exp.push_back(exp_vec(cfg_c, k));
      tick();
      e = q_exp.pop_front();
      n_checks++;
      if (w_obs !== e) $display("FAIL relatch k=%0d obs=%b exp=%b", k, w_obs, e); else n_pass++;
    end
    n_checks++;
    if (frame_cnt !== 16'd2) $display("FAIL zero_porch_frame_cnt obs=%0d exp=2", frame_cnt); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_underflow();
    logic e, found;
    logic [2:0] pv_seq [6];
    do_reset();
    apply_cfg(cfg_a);
    pix_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_udf.push_back(1'b0);
      tick();
      e = q_udf.pop_front();
      n_checks++;
      if (underflow !== e) $display("FAIL udf_no_de i=%0d obs=%b exp=%b", i, underflow, e); else n_pass++;
    end
    pix_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (DATA_ENB) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL udf_wait_de obs=timeout exp=DATA_ENB"); else n_pass++;
    // {pix_valid, udf_clr, expected underflow after the edge}
    pv_seq[0] = 3'b001; pv_seq[1] = 3'b101; pv_seq[2] = 3'b101;
    pv_seq[3] = 3'b101; pv_seq[4] = 3'b011; pv_seq[5] = 3'b110;
    for (int i = 0; i < 6; i++) begin
      pix_valid = pv_seq[i][2];
      udf_clr   = pv_seq[i][1];
      q_udf.push_back(pv_seq[i][0]);
      tick();
      e = q_udf.pop_front();
      n_checks++;
      if (underflow !== e) $display("FAIL udf_step i=%0d obs=%b exp=%b", i, underflow, e); else n_pass++;
    end
    udf_clr = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e;
    do_reset();
    apply_cfg(cfg_a);
    pix_valid = 1'b0;
    en = 1'b1;
    repeat (160) tick();
    n_checks++;
    if (w_obs !== exp_vec(cfg_a, 47)) $display("FAIL pre_reset_state obs=%b exp=%b", w_obs, exp_vec(cfg_a, 47)); else n_pass++;
    n_checks++;
    if (frame_cnt !== 16'd1 || underflow !== 1'b1)
      $display("FAIL pre_reset_status obs=%0d/%b exp=1/1", frame_cnt, underflow);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== 8'h00) $display("FAIL async_reset_outputs obs=%b exp=%b", w_obs, 8'h00); else n_pass++;
    n_checks++;
    if (frame_cnt !== 16'd0 || underflow !== 1'b0)
      $display("FAIL async_reset_status obs=%0d/%b exp=0/0", frame_cnt, underflow);
    else n_pass++;
    tick(); tick();
    rst = 1'b1;
    q_exp.push_back(exp_vec(cfg_a, 0));
    tick();
    e = q_exp.pop_front();
    n_checks++;
    if (w_obs !== e) $display("FAIL restart_first_edge obs=%b exp=%b", w_obs, e); else n_pass++;
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; pix_valid = 1'b1; udf_clr = 1'b0;
    apply_cfg(cfg_a);
    test_reset();
    test_frame_timing();
    test_stop_boundary();
    test_zero_porch();
    test_underflow();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
